// File: rtl/prbs_checker_if.sv
// Serial data/status bundle between a PRBS source and the checker.
// The checker drives the lock flag, the error pulse and the statistics counters.
interface prbs_checker_if #(
  parameter int unsigned CNT_W = 32
);
  logic             dataValid;
  logic             dataIn;
  logic             clear;
  logic             locked;
  logic             errorPulse;
  logic [CNT_W-1:0] bitCount;
  logic [CNT_W-1:0] errCount;
  logic [15:0]      lockLossCount;

  modport master (
    output dataValid, dataIn, clear,
    input  locked, errorPulse, bitCount, errCount, lockLossCount
  );

  modport slave (
    input  dataValid, dataIn, clear,
    output locked, errorPulse, bitCount, errCount, lockLossCount
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 32-bit XNOR LFSR stream (taps 32,22,2,1):
// fills its history in HUNT, checks bits in LOCK and drops lock on bad windows.
module prbs_checker #(
  parameter int unsigned WINDOW    = 1024,
  parameter int unsigned ERR_LIMIT = 8,
  parameter int unsigned CNT_W     = 32
) (
  input logic            clk,
  input logic            rst_n,
  prbs_checker_if.slave  bus
);

  localparam int unsigned HIST_W = 32;
  localparam int unsigned FILL_W = 6;
  localparam int unsigned WIN_W  = $clog2(WINDOW);
  localparam int unsigned WERR_W = $clog2(WINDOW + 1);
  localparam int unsigned LOSS_W = 16;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e              state_q,     state_d;
  logic [HIST_W-1:0]   hist_q,      hist_d;
  logic [FILL_W-1:0]   fill_q,      fill_d;
  logic [WIN_W-1:0]    win_cnt_q,   win_cnt_d;
  logic [WERR_W-1:0]   win_err_q,   win_err_d;
  logic                locked_q,    locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q,   err_cnt_d;
  logic [LOSS_W-1:0]   loss_cnt_q,  loss_cnt_d;

  logic [HIST_W-1:0]   hist_shift;
  logic [FILL_W-1:0]   fill_inc;
  logic [WERR_W-1:0]   win_err_nxt;
  logic                pred;
  logic                mismatch;
  logic                bit_inc;
  logic                err_inc;
  logic                loss_inc;

  // hist_q[0] is the newest bit, hist_q[31] the oldest.
  assign hist_shift  = {hist_q[HIST_W-2:0], bus.dataIn};
  assign pred        = ~(hist_q[31] ^ hist_q[21] ^ hist_q[1] ^ hist_q[0]);
  assign mismatch    = bus.dataIn ^ pred;
  assign fill_inc    = fill_q + FILL_W'(1);
  assign win_err_nxt = win_err_q + WERR_W'(mismatch);

  // Next-state, window bookkeeping and increment requests.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    bit_inc     = 1'b0;
    err_inc     = 1'b0;
    loss_inc    = 1'b0;

    if (bus.dataValid) begin
      hist_d = hist_shift;
      unique case (state_q)
        HUNT: begin
          if (fill_inc == FILL_W'(HIST_W)) begin
            fill_d = '0;
            // All-ones history is the XNOR lockup state and cannot predict.
            if (hist_shift != '1) begin
              state_d = LOCK;
            end
          end else begin
            fill_d = fill_inc;
          end
        end
        LOCK: begin
          bit_inc     = 1'b1;
          err_inc     = mismatch;
          err_pulse_d = mismatch;
          if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_nxt >= WERR_W'(ERR_LIMIT)) begin
              state_d  = HUNT;
              fill_d   = '0;
              loss_inc = 1'b1;
            end
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = win_err_nxt;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    locked_d = (state_d == LOCK);
  end

  // Statistics counters: clear wins over increment, otherwise saturate.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;
    loss_cnt_d = loss_cnt_q;
    if (bus.clear) begin
      bit_cnt_d  = '0;
      err_cnt_d  = '0;
      loss_cnt_d = '0;
    end else begin
      if (bit_inc && (bit_cnt_q != '1)) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      if (err_inc && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (loss_inc && (loss_cnt_q != '1)) begin
        loss_cnt_d = loss_cnt_q + LOSS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      hist_q      <= '0;
      fill_q      <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign bus.locked        = locked_q;
  assign bus.errorPulse    = err_pulse_q;
  assign bus.bitCount      = bit_cnt_q;
  assign bus.errCount      = err_cnt_q;
  assign bus.lockLossCount = loss_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, per-window error decisions, clear,
// gapped valid and mid-stream reset, against a seed-0 XNOR LFSR source.
module tb_prbs_checker;

  localparam int unsigned WIN = 64;
  localparam int unsigned LIM = 8;
  localparam int unsigned CW  = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  prbs_checker_if #(.CNT_W(CW)) bus ();

  prbs_checker #(
    .WINDOW   (WIN),
    .ERR_LIMIT(LIM),
    .CNT_W    (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          n_pulse = 0;
  logic [31:0] gen     = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference source: newest bit = XNOR of taps 32,22,2,1.
  task automatic next_good(output logic b);
    b   = ~(gen[31] ^ gen[21] ^ gen[1] ^ gen[0]);
    gen = {gen[30:0], b};
  endtask

  task automatic step(input logic v, input logic d, input logic clr);
    @(negedge clk);
    bus.dataValid = v;
    bus.dataIn    = d;
    bus.clear     = clr;
    @(posedge clk);
    #1;
    if (bus.errorPulse) n_pulse++;
  endtask

  task automatic good(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_good(b);
      step(1'b1, b, 1'b0);
    end
  endtask

  function automatic logic fbit(input logic [63:0] m, input int i);
    return (i < 0) ? 1'b0 : m[i];
  endfunction

  // One window with flipped bits; a flipped bit also corrupts the history, so
  // bit n mismatches when an odd number of bits n, n-1, n-2, n-22, n-32 are flipped.
  task automatic run_window(input logic [63:0] fmask);
    logic b;
    logic e;
    for (int n = 0; n < int'(WIN); n++) begin
      next_good(b);
      step(1'b1, b ^ fmask[n], 1'b0);
      e = fbit(fmask, n) ^ fbit(fmask, n - 1) ^ fbit(fmask, n - 2)
        ^ fbit(fmask, n - 22) ^ fbit(fmask, n - 32);
      check($sformatf("pulse@%0d", n), 32'(bus.errorPulse), 32'(e));
      if (n == int'(WIN) - 2) check("locked_pre_boundary", 32'(bus.locked), 32'd1);
    end
  endtask

  initial begin
    logic        b;
    logic [63:0] mask;
    int          nv;

    bus.dataValid = 1'b0;
    bus.dataIn    = 1'b0;
    bus.clear     = 1'b0;
    rst_n         = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_pulse",  32'(bus.errorPulse), 32'd0);
    check("rst_bits",   bus.bitCount, 32'd0);
    check("rst_errs",   bus.errCount, 32'd0);
    check("rst_loss",   32'(bus.lockLossCount), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream: lock on the 32nd bit, then 1000 error-free checked bits.
    good(31);
    check("fill31_locked", 32'(bus.locked), 32'd0);
    good(1);
    check("fill32_locked", 32'(bus.locked), 32'd1);
    n_pulse = 0;
    good(1000);
    check("clean_bits",   bus.bitCount, 32'd1000);
    check("clean_errs",   bus.errCount, 32'd0);
    check("clean_pulses", 32'(n_pulse), 32'd0);

    // 1000 mod 64 = 40, so 24 more bits reach a window start.
    good(24);
    step(1'b0, 1'b0, 1'b1);
    check("clr_idle_bits", bus.bitCount, 32'd0);

    // One flip gives 5 mismatches: below the limit, lock held.
    n_pulse = 0;
    mask    = '0;
    mask[4] = 1'b1;
    run_window(mask);
    check("w1_errs",   bus.errCount, 32'd5);
    check("w1_pulses", 32'(n_pulse), 32'd5);
    check("w1_locked", 32'(bus.locked), 32'd1);
    check("w1_bits",   bus.bitCount, 32'd64);

    // Errors 20,21,22,42,52,61,62,63: the closing bit is the 8th -> lock lost.
    mask     = '0;
    mask[20] = 1'b1;
    mask[61] = 1'b1;
    run_window(mask);
    check("w2_locked", 32'(bus.locked), 32'd0);
    check("w2_loss",   32'(bus.lockLossCount), 32'd1);
    check("w2_errs",   bus.errCount, 32'd13);

    good(31);
    check("relock31_locked", 32'(bus.locked), 32'd0);
    good(1);
    check("relock32_locked", 32'(bus.locked), 32'd1);
    check("relock_bits",     bus.bitCount, 32'd128);

    // Clear on a flipped bit: counters zero, the pulse still appears.
    good(10);
    next_good(b);
    step(1'b1, ~b, 1'b1);
    check("clr_pulse", 32'(bus.errorPulse), 32'd1);
    check("clr_bits",  bus.bitCount, 32'd0);
    check("clr_errs",  bus.errCount, 32'd0);
    check("clr_loss",  32'(bus.lockLossCount), 32'd0);
    good(1);
    check("postclr_pulse", 32'(bus.errorPulse), 32'd1);
    check("postclr_bits",  bus.bitCount, 32'd1);
    check("postclr_errs",  bus.errCount, 32'd1);
    good(40);
    check("clr_win_errs",   bus.errCount, 32'd4);
    good(12);
    check("clr_win_locked", 32'(bus.locked), 32'd1);

    // Gapped valid over a good stream.
    step(1'b0, 1'b0, 1'b1);
    nv      = 0;
    n_pulse = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        next_good(b);
        step(1'b1, b, 1'b0);
        nv++;
      end else begin
        step(1'b0, 1'($urandom), 1'b0);
      end
    end
    check("gap_bits",   bus.bitCount, 32'(nv));
    check("gap_errs",   bus.errCount, 32'd0);
    check("gap_pulses", 32'(n_pulse), 32'd0);
    check("gap_locked", 32'(bus.locked), 32'd1);

    // Asynchronous reset mid-window, then an all-ones fill that must not lock.
    @(negedge clk);
    bus.dataValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_locked", 32'(bus.locked), 32'd0);
    check("arst_bits",   bus.bitCount, 32'd0);
    check("arst_loss",   32'(bus.lockLossCount), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b0);
    check("ones_locked", 32'(bus.locked), 32'd0);
    good(31);
    check("after_ones31_locked", 32'(bus.locked), 32'd0);
    good(1);
    check("after_ones32_locked", 32'(bus.locked), 32'd1);
    good(1);
    check("after_ones_bits", bus.bitCount, 32'd1);
    check("after_ones_errs", bus.errCount, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
